// File: rtl/tdm_demux_sixteen.sv
// tdm_demux_sixteen
//   Receive-side TDM demultiplexer. Rebuilds 16-channel serial frames
//   (channel 0 first, flagged by frame_sync) into a parallel word. A
//   HUNT/RECV state machine keeps word alignment. Each completed frame is
//   presented as a registered word with a one-cycle strobe.
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   din         serial channel sample
//   din_valid   sample qualifier; idle cycles leave all state untouched
//   frame_sync  marks the current valid sample as channel 0
//   sel_out     channel index the next accepted sample is written to
//   dout        last completed frame, dout[k] = channel k
//   dout_valid  one-cycle pulse when dout is updated
//   frame_err   one-cycle pulse on a sync error
//   locked      high while aligned (RECV)
module tdm_demux_sixteen #(
  parameter int NUM_CH = 16,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [SEL_W-1:0]  sel_out,
  output logic [NUM_CH-1:0] dout,
  output logic              dout_valid,
  output logic              frame_err,
  output logic              locked
);

  typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_e;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W-1:0] ONE     = SEL_W'(1);

  state_e              state_q;
  logic [SEL_W-1:0]    cnt_q;
  logic [SEL_W-1:0]    cnt_d;
  logic [NUM_CH-1:0]   shadow_q;
  logic [NUM_CH-1:0]   dout_q;
  logic                dout_valid_q;
  logic                frame_err_q;

  // Increment only ever used for cnt in 1..14; the 15->0 wrap is handled
  // by its own branch below.
  assign cnt_d = cnt_q + ONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= HUNT;
      cnt_q        <= '0;
      shadow_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (din_valid) begin
        case (state_q)
          HUNT: begin
            // Unsynced samples are simply dropped while hunting.
            if (frame_sync) begin
              shadow_q[0] <= din;
              cnt_q       <= ONE;
              state_q     <= RECV;
            end
          end
          RECV: begin
            if (frame_sync) begin
              // Sync mid-frame: drop the partial frame and realign on this
              // sample without losing a cycle.
              if (cnt_q != '0) frame_err_q <= 1'b1;
              shadow_q[0] <= din;
              cnt_q       <= ONE;
            end else if (cnt_q == '0) begin
              // Frame boundary expected but no sync: lose lock.
              frame_err_q <= 1'b1;
              state_q     <= HUNT;
            end else if (cnt_q == LAST_CH) begin
              dout_q       <= {din, shadow_q[NUM_CH-2:0]};
              dout_valid_q <= 1'b1;
              cnt_q        <= '0;
            end else begin
              shadow_q[cnt_q] <= din;
              cnt_q           <= cnt_d;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign sel_out    = cnt_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;
  assign locked     = (state_q == RECV);

endmodule

// File: tb/tb_tdm_demux_sixteen.sv
module tb_tdm_demux_sixteen;

  logic        clk = 1'b0;
  logic        reset;
  logic        din;
  logic        din_valid;
  logic        frame_sync;
  logic [3:0]  sel_out;
  logic [15:0] dout;
  logic        dout_valid;
  logic        frame_err;
  logic        locked;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  logic [15:0] exp_q[$];
  int          dv_cyc_q[$];

  tdm_demux_sixteen #(.NUM_CH(16), .SEL_W(4)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .sel_out(sel_out), .dout(dout),
    .dout_valid(dout_valid), .frame_err(frame_err), .locked(locked)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard: every dout_valid pops the word expected for that frame.
  always @(negedge clk) begin
    if (!reset) begin
      if (dout_valid) begin
        dv_cnt++;
        dv_cyc_q.push_back(cyc);
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected_dout_valid dout=%h expected no frame", dout);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (dout !== e) begin
            fails++;
            $display("FAIL sb_dout got=%h exp=%h", dout, e);
          end
        end
      end
      if (frame_err) fe_cnt++;
    end
  end

  task automatic send_sample(input logic fs, input logic d);
    din_valid = 1'b1; frame_sync = fs; din = d;
    @(posedge clk); #1;
    din_valid = 1'b0; frame_sync = 1'b0; din = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [15:0] w, input logic sync);
    if (sync) exp_q.push_back(w);
    for (int i = 0; i < 16; i++) send_sample(sync && (i == 0), w[i]);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; din = 0; din_valid = 0; frame_sync = 0;
    repeat (2) @(posedge clk); #1;
    chk("rst_sel_out", 16'(sel_out), 16'h0);
    chk("rst_dout", dout, 16'h0);
    chk("rst_dout_valid", 16'(dout_valid), 16'h0);
    chk("rst_frame_err", 16'(frame_err), 16'h0);
    chk("rst_locked", 16'(locked), 16'h0);
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_basic;
    int dv0;
    logic [15:0] bits;
    dv0 = dv_cnt;
    // channel 0 first: 1,0,1,1, 0,0,0,0, 1,1,1,1, 0,1,0,1
    bits = 16'b1010_1111_0000_1101;
    send_frame(bits, 1'b1);
    chk("basic_dout", dout, 16'hAF0D);
    chk("basic_dout_valid", 16'(dout_valid), 16'h1);
    chk("basic_locked", 16'(locked), 16'h1);
    chk("basic_sel_out", 16'(sel_out), 16'h0);
    idle(1);
    chk("basic_dv_pulse_width", 16'(dout_valid), 16'h0);
    chk("basic_dv_count", 16'(dv_cnt - dv0), 16'h1);
  endtask

  task automatic test_back_to_back;
    int dv0, fe0;
    dv0 = dv_cnt; fe0 = fe_cnt;
    dv_cyc_q.delete();
    send_frame(16'h1234, 1'b1);
    send_frame(16'hFFFF, 1'b1);
    idle(2);
    chk("b2b_dv_count", 16'(dv_cnt - dv0), 16'h2);
    chk("b2b_frame_err", 16'(fe_cnt - fe0), 16'h0);
    if (dv_cyc_q.size() == 2)
      chk("b2b_dv_spacing", 16'(dv_cyc_q[1] - dv_cyc_q[0]), 16'd16);
    else
      chk("b2b_dv_records", 16'(dv_cyc_q.size()), 16'h2);
    chk("b2b_dout_last", dout, 16'hFFFF);
  endtask

  task automatic test_gaps;
    int gap_after[16];
    int c0, dv0;
    logic [15:0] w;
    w = 16'h00FF;
    foreach (gap_after[i]) gap_after[i] = 0;
    for (int g = 0; g < 3; g++) gap_after[$urandom_range(0, 14)]++;
    dv0 = dv_cnt;
    dv_cyc_q.delete();
    exp_q.push_back(w);
    c0 = cyc;
    for (int i = 0; i < 16; i++) begin
      send_sample(i == 0, w[i]);
      for (int k = 0; k < gap_after[i]; k++) begin
        idle(1);
        chk("gap_sel_out_frozen", 16'(sel_out), 16'(i + 1));
      end
    end
    idle(1);
    chk("gap_dv_count", 16'(dv_cnt - dv0), 16'h1);
    if (dv_cyc_q.size() == 1)
      chk("gap_dv_latency", 16'(dv_cyc_q[0] - c0), 16'd19);
    chk("gap_dout", dout, 16'h00FF);
  endtask

  task automatic test_early_sync;
    int dv0, fe0;
    logic [15:0] w;
    w = 16'hA5A5;
    dv0 = dv_cnt; fe0 = fe_cnt;
    for (int i = 0; i < 7; i++) send_sample(i == 0, 1'($urandom_range(0, 1)));
    exp_q.push_back(w);
    for (int i = 0; i < 16; i++) begin
      send_sample(i == 0, w[i]);
      if (i == 0) begin
        chk("early_frame_err", 16'(frame_err), 16'h1);
        chk("early_locked", 16'(locked), 16'h1);
      end
    end
    idle(1);
    chk("early_dv_count", 16'(dv_cnt - dv0), 16'h1);
    chk("early_fe_count", 16'(fe_cnt - fe0), 16'h1);
    chk("early_dout", dout, 16'hA5A5);
    chk("early_locked_after", 16'(locked), 16'h1);
  endtask

  task automatic test_missing_sync;
    int dv0, fe0;
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_sample(1'b0, 1'b1);
    chk("nosync_frame_err", 16'(frame_err), 16'h1);
    chk("nosync_locked", 16'(locked), 16'h0);
    chk("nosync_dout_hold", dout, 16'hA5A5);
    for (int i = 0; i < 5; i++) send_sample(1'b0, 1'($urandom_range(0, 1)));
    idle(1);
    chk("hunt_fe_count", 16'(fe_cnt - fe0), 16'h1);
    chk("hunt_dv_count", 16'(dv_cnt - dv0), 16'h0);
    chk("hunt_locked", 16'(locked), 16'h0);
    chk("hunt_sel_out", 16'(sel_out), 16'h0);
    send_frame(16'h8001, 1'b1);
    idle(1);
    chk("relock_dout", dout, 16'h8001);
    chk("relock_locked", 16'(locked), 16'h1);
  endtask

  task automatic test_reset_mid;
    int dv0, fe0;
    for (int i = 0; i < 9; i++) send_sample(i == 0, 1'b1);
    chk("mid_sel_out_9", 16'(sel_out), 16'd9);
    reset = 1'b1;
    #1;
    chk("async_rst_sel_out", 16'(sel_out), 16'h0);
    chk("async_rst_dout", dout, 16'h0);
    chk("async_rst_locked", 16'(locked), 16'h0);
    chk("async_rst_flags", {14'h0, dout_valid, frame_err}, 16'h0);
    idle(1);
    reset = 1'b0;
    idle(1);
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(16'h5A5A, 1'b0);
    idle(2);
    chk("post_rst_dv_count", 16'(dv_cnt - dv0), 16'h0);
    chk("post_rst_fe_count", 16'(fe_cnt - fe0), 16'h0);
    chk("post_rst_locked", 16'(locked), 16'h0);
    chk("post_rst_dout", dout, 16'h0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_gaps();
    test_early_sync();
    test_missing_sync();
    test_reset_mid();
    chk("sb_drained", 16'(exp_q.size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tdm_demux_sixteen.md
Name: tdm_demux_sixteen

Overview:
- Receive-side partner of the 16:1 channel mux: a time-division demultiplexer.
- Takes a serial bit stream of 16-channel frames (channel 0 first, marked by frame_sync) and rebuilds the 16 channel bits into one parallel word.
- Holds word alignment with a hunt/receive state machine, flags sync errors, and presents each completed frame as a registered word with a one-cycle strobe.
- Sits between the link's serial path and the parallel consumer logic.

Parameters:
- NUM_CH, 16, channels per frame; only 16 is supported.
- SEL_W, 4, width of the channel counter and sel_out; equals log2(NUM_CH).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  1  serial channel sample.
- din_valid  input  1  din is a valid sample this cycle; cycles with din_valid low are ignored (no state change).
- frame_sync  input  1  qualified by din_valid; marks the current sample as channel 0.
- sel_out  output  SEL_W  channel index the next accepted sample is written to.
- dout  output  NUM_CH  last completed frame; dout[k] = channel k (transmitter input din_k).
- dout_valid  output  1  one-cycle pulse; dout updated this cycle.
- frame_err  output  1  one-cycle pulse on a sync error.
- locked  output  1  high while in RECV.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high.
- Reset values (asynchronous, take effect immediately):
  - state = HUNT, internal counter cnt = 0, shadow register = 0.
  - sel_out = 0, dout = 0, dout_valid = 0, frame_err = 0, locked = 0.
- Registered outputs:
  - sel_out = cnt; locked = (state == RECV).
  - dout_valid and frame_err default to 0 every cycle and are high only for the single cycle stated below.
- HUNT state:
  - Valid sample without frame_sync: discarded, no pulse.
  - Valid sample with frame_sync: shadow[0] <= din, cnt <= 1, state <= RECV.
- RECV state, valid sample with frame_sync low:
  - cnt in 1..14: shadow[cnt] <= din, cnt <= cnt+1.
  - cnt == 15: dout <= {din, shadow[14:0]}, dout_valid <= 1 on the next edge, cnt <= 0, stay RECV. Latency is one clock from acceptance of channel 15 to dout/dout_valid.
  - cnt == 0 (a new frame must start but sync is missing): sample discarded, frame_err <= 1, state <= HUNT, cnt <= 0, dout unchanged.
- RECV state, valid sample with frame_sync high:
  - cnt == 0: normal frame start; shadow[0] <= din, cnt <= 1.
  - cnt in 1..15 (early sync): partial frame discarded with no dout_valid, frame_err <= 1, then shadow[0] <= din and cnt <= 1; stay RECV. Re-alignment takes no extra cycles.
- Back-to-back frames:
  - Channel 15 of frame N and channel 0 of frame N+1 may arrive on consecutive cycles; no bubble is required.
  - dout_valid for frame N coincides with the first sample of frame N+1 being accepted.
- Gaps: din_valid may drop at any point mid-frame; cnt, shadow and state hold indefinitely. There is no timeout.
- Shadow contents:
  - Stale bits never leak into dout, because every bit is rewritten before any dout update.
  - shadow is not cleared on error; only reset clears it.
- dout holds its value until the next completed frame or reset.
- Reset mid-frame: partial frame lost; first post-reset frame requires frame_sync.
- Counter arithmetic: SEL_W-bit unsigned; the 15→0 wrap is explicit, never modulo overflow of a wider register.

Test Plan:
- Reset, then 16 consecutive valid samples with sync on the first, bits 1,0,1,1, 0,0,0,0, 1,1,1,1, 0,1,0,1 (channel 0 first) -> one cycle after channel 15: dout = 16'hAF0D, dout_valid high one cycle, locked = 1, sel_out = 0.
- Two frames back-to-back, 16'h1234 then 16'hFFFF, no gap -> dout_valid pulses exactly 16 cycles apart, dout = 16'h1234 then 16'hFFFF, frame_err never asserts.
- Frame 16'h00FF with din_valid low for 3 random cycles inserted mid-frame -> dout = 16'h00FF, dout_valid delayed by exactly 3 cycles, sel_out frozen during the gaps.
- frame_sync asserted again after 7 samples, then a full 16-sample frame 16'hA5A5 -> frame_err pulse on that sample, no dout_valid for the partial frame, dout = 16'hA5A5, locked stays 1.
- After a good frame, a valid sample at cnt = 0 with frame_sync low -> frame_err pulse, locked = 0, dout holds the previous value; 5 more unsynced samples produce no response; then a synced frame 16'h8001 -> dout = 16'h8001.
- Assert reset while cnt = 9 -> all outputs 0 immediately (before the next clk edge); a frame sent without frame_sync afterwards is ignored.
